// File: rtl/cache_miss_unit_pkg.sv
// Shared types for the cache miss unit: memory request format, line/address widths, FSM states.
package cache_miss_unit_pkg;

    localparam int unsigned ADDR_WIDTH        = 32;
    localparam int unsigned DCACHE_LINE_WIDTH = 128;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]        addr;
        logic                         is_store;
        logic [DCACHE_LINE_WIDTH-1:0] data;
    } memory_request_t;

    typedef enum logic [2:0] {
        StIdle,
        StWbReq,
        StWbWait,
        StFillReq,
        StFillWait,
        StRefill
    } miss_state_t;

    // Watchdog counter width; at least one bit so TIMEOUT=1 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/miss_watchdog.sv
// Wait-state watchdog: counts enabled cycles and flags expiry at TIMEOUT-1.
module miss_watchdog
    import cache_miss_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int unsigned    CntW   = cnt_width(TIMEOUT);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign expire_o = enable_i && (cnt_q == CntMax);

    // Next count: cleared outside wait states and on expiry, so it never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_miss_unit.sv
// Cache miss unit: optional dirty-victim writeback, then line refill, with a wait-state watchdog.
module cache_miss_unit
    import cache_miss_unit_pkg::*;
#(
    parameter logic        CACHE_ID = 1'b1,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         miss_valid_i,
    input  logic [ADDR_WIDTH-1:0]        miss_addr_i,
    input  logic                         evict_valid_i,
    input  logic [ADDR_WIDTH-1:0]        evict_addr_i,
    input  logic [DCACHE_LINE_WIDTH-1:0] evict_data_i,
    output logic                         miss_ready_o,
    output logic                         req_valid_miss,
    output memory_request_t              req_info_miss,
    input  logic                         rsp_valid_miss,
    input  logic                         rsp_cache_id,
    input  logic [DCACHE_LINE_WIDTH-1:0] rsp_data_miss,
    output logic                         fill_valid_o,
    output logic [ADDR_WIDTH-1:0]        fill_addr_o,
    output logic [DCACHE_LINE_WIDTH-1:0] fill_data_o,
    output logic                         timeout_o
);

    miss_state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]        miss_addr_q, miss_addr_d;
    logic [ADDR_WIDTH-1:0]        evict_addr_q, evict_addr_d;
    logic [DCACHE_LINE_WIDTH-1:0] evict_data_q, evict_data_d;
    logic [DCACHE_LINE_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic rsp_match;
    logic in_wait;
    logic wd_expire;

    assign rsp_match = rsp_valid_miss && (rsp_cache_id == CACHE_ID);
    assign in_wait   = (state_q == StWbWait) || (state_q == StFillWait);

    // Held at zero outside the wait states, so it starts fresh on each wait entry.
    miss_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (!in_wait),
        .enable_i (in_wait),
        .expire_o (wd_expire)
    );

    assign fill_addr_o = miss_addr_q;
    assign fill_data_o = rsp_data_q;

    // Next-state, input capture and request/fill/timeout outputs.
    always_comb begin
        state_d        = state_q;
        miss_addr_d    = miss_addr_q;
        evict_addr_d   = evict_addr_q;
        evict_data_d   = evict_data_q;
        rsp_data_d     = rsp_data_q;
        miss_ready_o   = 1'b0;
        req_valid_miss = 1'b0;
        req_info_miss  = '0;
        fill_valid_o   = 1'b0;
        timeout_o      = 1'b0;

        case (state_q)
            StIdle: begin
                miss_ready_o = 1'b1;
                if (miss_valid_i) begin
                    miss_addr_d  = miss_addr_i;
                    evict_addr_d = evict_addr_i;
                    evict_data_d = evict_data_i;
                    state_d      = evict_valid_i ? StWbReq : StFillReq;
                end
            end
            StWbReq: begin
                req_valid_miss = 1'b1;
                req_info_miss  = '{addr: evict_addr_q, is_store: 1'b1, data: evict_data_q};
                state_d        = StWbWait;
            end
            StWbWait: begin
                req_info_miss = '{addr: evict_addr_q, is_store: 1'b1, data: evict_data_q};
                if (rsp_match) begin
                    state_d = StFillReq;
                end else if (wd_expire) begin
                    timeout_o = 1'b1;
                    state_d   = StIdle;
                end
            end
            StFillReq: begin
                req_valid_miss = 1'b1;
                req_info_miss  = '{addr: miss_addr_q, is_store: 1'b0, data: '0};
                state_d        = StFillWait;
            end
            StFillWait: begin
                req_info_miss = '{addr: miss_addr_q, is_store: 1'b0, data: '0};
                // A match on the expiry cycle still completes the refill.
                if (rsp_match) begin
                    rsp_data_d = rsp_data_miss;
                    state_d    = StRefill;
                end else if (wd_expire) begin
                    timeout_o = 1'b1;
                    state_d   = StIdle;
                end
            end
            StRefill: begin
                fill_valid_o = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and captured request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            miss_addr_q  <= '0;
            evict_addr_q <= '0;
            evict_data_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            evict_addr_q <= evict_addr_d;
            evict_data_q <= evict_data_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_cache_miss_unit.sv
// Self-checking bench for cache_miss_unit: scoreboard of expected requests, fills and timeouts.
module tb_cache_miss_unit;
    import cache_miss_unit_pkg::*;

    typedef logic [ADDR_WIDTH-1:0]        addr_t;
    typedef logic [DCACHE_LINE_WIDTH-1:0] line_t;
    typedef struct { memory_request_t info; int cyc; } req_exp_t;
    typedef struct { addr_t addr; line_t data; int cyc; } fill_exp_t;

    logic            clk;
    logic            rst_n;
    logic            miss_valid_i;
    addr_t           miss_addr_i;
    logic            evict_valid_i;
    addr_t           evict_addr_i;
    line_t           evict_data_i;
    logic            miss_ready_o;
    logic            req_valid_miss;
    memory_request_t req_info_miss;
    logic            rsp_valid_miss;
    logic            rsp_cache_id;
    line_t           rsp_data_miss;
    logic            fill_valid_o;
    addr_t           fill_addr_o;
    line_t           fill_data_o;
    logic            timeout_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    req_exp_t  exp_req[$];
    fill_exp_t exp_fill[$];
    int        exp_tmo[$];

    cache_miss_unit #(
        .CACHE_ID (1'b1),
        .TIMEOUT  (64)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_valid_i   (miss_valid_i),
        .miss_addr_i    (miss_addr_i),
        .evict_valid_i  (evict_valid_i),
        .evict_addr_i   (evict_addr_i),
        .evict_data_i   (evict_data_i),
        .miss_ready_o   (miss_ready_o),
        .req_valid_miss (req_valid_miss),
        .req_info_miss  (req_info_miss),
        .rsp_valid_miss (rsp_valid_miss),
        .rsp_cache_id   (rsp_cache_id),
        .rsp_data_miss  (rsp_data_miss),
        .fill_valid_o   (fill_valid_o),
        .fill_addr_o    (fill_addr_o),
        .fill_data_o    (fill_data_o),
        .timeout_o      (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_time_limit: got cycle %0d, required finish before limit", cyc);
        $fatal(1, "simulation time limit reached");
    end

    // Pop and compare the scoreboard whenever the DUT produces an output event.
    task automatic scoreboard_sample();
        req_exp_t  er;
        fill_exp_t ef;
        int        et;
        if (rst_n) begin
            if (req_valid_miss) begin
                n_checks++;
                if (exp_req.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_req_unexpected: got req %h at cyc %0d, required none",
                             req_info_miss, cyc);
                end else begin
                    er = exp_req.pop_front();
                    if (req_info_miss !== er.info || cyc != er.cyc) begin
                        n_fail++;
                        $display("FAIL sb_req: got %h at cyc %0d, required %h at cyc %0d",
                                 req_info_miss, cyc, er.info, er.cyc);
                    end
                end
            end
            if (fill_valid_o) begin
                n_checks++;
                if (exp_fill.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_fill_unexpected: got addr %h at cyc %0d, required none",
                             fill_addr_o, cyc);
                end else begin
                    ef = exp_fill.pop_front();
                    if (fill_addr_o !== ef.addr || fill_data_o !== ef.data || cyc != ef.cyc) begin
                        n_fail++;
                        $display("FAIL sb_fill: got %h/%h at cyc %0d, required %h/%h at cyc %0d",
                                 fill_addr_o, fill_data_o, cyc, ef.addr, ef.data, ef.cyc);
                    end
                end
            end
            if (timeout_o) begin
                n_checks++;
                if (exp_tmo.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_timeout_unexpected: got pulse at cyc %0d, required none", cyc);
                end else begin
                    et = exp_tmo.pop_front();
                    if (cyc != et) begin
                        n_fail++;
                        $display("FAIL sb_timeout: got pulse at cyc %0d, required cyc %0d", cyc, et);
                    end
                end
            end
        end
    endtask

    // Advance one cycle: sample at negedge, then land 1 unit after the next posedge.
    task automatic cycle();
        @(negedge clk);
        scoreboard_sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_req(input addr_t a, input logic st, input line_t d, input int c);
        req_exp_t e;
        e.info = '{addr: a, is_store: st, data: d};
        e.cyc  = c;
        exp_req.push_back(e);
    endtask

    task automatic push_fill(input addr_t a, input line_t d, input int c);
        fill_exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_fill.push_back(e);
    endtask

    task automatic drive_miss(input addr_t a, input logic ev, input addr_t ea, input line_t ed);
        miss_valid_i  = 1'b1;
        miss_addr_i   = a;
        evict_valid_i = ev;
        evict_addr_i  = ea;
        evict_data_i  = ed;
    endtask

    task automatic drive_rsp(input logic id, input line_t d);
        rsp_valid_miss = 1'b1;
        rsp_cache_id   = id;
        rsp_data_miss  = d;
    endtask

    task automatic idle_inputs();
        miss_valid_i   = 1'b0;
        evict_valid_i  = 1'b0;
        rsp_valid_miss = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        miss_addr_i = '0; evict_addr_i = '0; evict_data_i = '0;
        rsp_cache_id = 1'b0; rsp_data_miss = '0;
        #1 rst_n = 1'b0;
        #2;
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", miss_ready_o); end
        n_checks++; if (req_valid_miss !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b required 0", req_valid_miss); end
        n_checks++; if (req_info_miss !== '0) begin n_fail++; $display("FAIL reset_req_info: got %h required 0", req_info_miss); end
        n_checks++; if (fill_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_fill_valid: got %b required 0", fill_valid_o); end
        n_checks++; if (fill_addr_o !== '0) begin n_fail++; $display("FAIL reset_fill_addr: got %h required 0", fill_addr_o); end
        n_checks++; if (fill_data_o !== '0) begin n_fail++; $display("FAIL reset_fill_data: got %h required 0", fill_data_o); end
        n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b required 0", timeout_o); end
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_clean_miss();
        int    c, r;
        line_t d;
        d = {4{32'hCAFE_0001}};
        c = cyc;
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL clean_ready_pre: got %b required 1", miss_ready_o); end
        drive_miss(32'h40, 1'b0, 32'h0, '0);
        push_req(32'h40, 1'b0, '0, c + 1);
        cycle();
        idle_inputs();
        repeat (10) cycle();
        n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL clean_ready_wait: got %b required 0", miss_ready_o); end
        r = cyc;
        drive_rsp(1'b1, d);
        push_fill(32'h40, d, r + 1);
        cycle();
        idle_inputs();
        n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL clean_ready_refill: got %b required 0", miss_ready_o); end
        cycle();
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL clean_ready_post: got %b required 1 at rsp+2", miss_ready_o); end
        n_checks++; if (exp_req.size() + exp_fill.size() != 0) begin n_fail++; $display("FAIL clean_pending: got %0d outstanding, required 0", exp_req.size() + exp_fill.size()); end
    endtask

    task automatic test_dirty_miss();
        int    c, r1, r2;
        line_t ed, d;
        ed = {16{8'hAB}};
        d  = {4{32'h1234_5678}};
        c = cyc;
        drive_miss(32'h20, 1'b1, 32'h10, ed);
        push_req(32'h10, 1'b1, ed, c + 1);
        cycle();
        idle_inputs();
        repeat (5) cycle();
        r1 = cyc;
        drive_rsp(1'b1, {4{32'hDEAD_BEEF}});
        push_req(32'h20, 1'b0, '0, r1 + 1);
        cycle();
        idle_inputs();
        repeat (4) cycle();
        r2 = cyc;
        drive_rsp(1'b1, d);
        push_fill(32'h20, d, r2 + 1);
        cycle();
        idle_inputs();
        cycle();
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL dirty_ready_post: got %b required 1", miss_ready_o); end
        n_checks++; if (exp_req.size() + exp_fill.size() != 0) begin n_fail++; $display("FAIL dirty_pending: got %0d outstanding, required 0", exp_req.size() + exp_fill.size()); end
    endtask

    task automatic test_wrong_owner();
        int    c, r;
        line_t d;
        d = {4{32'h0BAD_F00D}};
        c = cyc;
        drive_miss(32'h80, 1'b0, 32'h0, '0);
        push_req(32'h80, 1'b0, '0, c + 1);
        cycle();
        idle_inputs();
        repeat (3) cycle();
        drive_rsp(1'b0, {4{32'hFFFF_FFFF}});
        cycle();
        idle_inputs();
        repeat (3) cycle();
        n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL owner_still_waiting: got ready %b required 0", miss_ready_o); end
        r = cyc;
        drive_rsp(1'b1, d);
        push_fill(32'h80, d, r + 1);
        cycle();
        idle_inputs();
        cycle();
        n_checks++; if (exp_req.size() + exp_fill.size() != 0) begin n_fail++; $display("FAIL owner_pending: got %0d outstanding, required 0", exp_req.size() + exp_fill.size()); end
    endtask

    task automatic test_timeout();
        int    c;
        line_t d;
        // No response: expiry on the 64th wait cycle.
        c = cyc;
        drive_miss(32'hA0, 1'b0, 32'h0, '0);
        push_req(32'hA0, 1'b0, '0, c + 1);
        exp_tmo.push_back(c + 65);
        cycle();
        idle_inputs();
        repeat (64) cycle();
        n_checks++; if (timeout_o !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse: got %b required 1 at cyc %0d", timeout_o, cyc); end
        n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL tmo_ready_during: got %b required 0", miss_ready_o); end
        cycle();
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL tmo_ready_after: got %b required 1", miss_ready_o); end
        n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_single_pulse: got %b required 0", timeout_o); end
        n_checks++; if (exp_tmo.size() != 0) begin n_fail++; $display("FAIL tmo_pending: got %0d outstanding, required 0", exp_tmo.size()); end
        // Response on the expiry cycle: match wins.
        d = {4{32'h6363_6363}};
        c = cyc;
        drive_miss(32'hB0, 1'b0, 32'h0, '0);
        push_req(32'hB0, 1'b0, '0, c + 1);
        cycle();
        idle_inputs();
        repeat (64) cycle();
        drive_rsp(1'b1, d);
        push_fill(32'hB0, d, c + 66);
        #1;
        n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL tmo_match_wins: got %b required 0", timeout_o); end
        cycle();
        idle_inputs();
        cycle();
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL tmo_match_ready: got %b required 1", miss_ready_o); end
        n_checks++; if (exp_req.size() + exp_fill.size() != 0) begin n_fail++; $display("FAIL tmo_match_pending: got %0d outstanding, required 0", exp_req.size() + exp_fill.size()); end
    endtask

    task automatic test_reset_mid();
        int c;
        c = cyc;
        drive_miss(32'hC0, 1'b0, 32'h0, '0);
        push_req(32'hC0, 1'b0, '0, c + 1);
        cycle();
        idle_inputs();
        repeat (3) cycle();
        rst_n = 1'b0;
        #2;
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b required 1", miss_ready_o); end
        n_checks++; if (req_info_miss !== '0) begin n_fail++; $display("FAIL rstmid_req_info: got %h required 0", req_info_miss); end
        n_checks++; if (fill_addr_o !== '0) begin n_fail++; $display("FAIL rstmid_fill_addr: got %h required 0", fill_addr_o); end
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        drive_rsp(1'b1, {4{32'h5555_AAAA}});
        cycle();
        idle_inputs();
        repeat (3) cycle();
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready_after: got %b required 1", miss_ready_o); end
        n_checks++; if (fill_data_o !== '0) begin n_fail++; $display("FAIL rstmid_fill_data: got %h required 0", fill_data_o); end
        n_checks++; if (exp_req.size() + exp_fill.size() != 0) begin n_fail++; $display("FAIL rstmid_pending: got %0d outstanding, required 0", exp_req.size() + exp_fill.size()); end
    endtask

    task automatic test_back_to_back();
        int    c, r, r2;
        line_t d1, d2;
        d1 = {4{32'h1111_2222}};
        d2 = {4{32'h3333_4444}};
        c = cyc;
        drive_miss(32'h100, 1'b0, 32'h0, '0);
        push_req(32'h100, 1'b0, '0, c + 1);
        cycle();
        miss_addr_i = 32'h140;
        repeat (4) cycle();
        r = cyc;
        drive_rsp(1'b1, d1);
        push_fill(32'h100, d1, r + 1);
        push_req(32'h140, 1'b0, '0, r + 3);
        cycle();
        rsp_valid_miss = 1'b0;
        n_checks++; if (miss_ready_o !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_refill: got %b required 0", miss_ready_o); end
        cycle();
        n_checks++; if (miss_ready_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b required 1", miss_ready_o); end
        cycle();
        miss_valid_i = 1'b0;
        cycle();
        r2 = cyc;
        drive_rsp(1'b1, d2);
        push_fill(32'h140, d2, r2 + 1);
        cycle();
        idle_inputs();
        cycle();
        n_checks++; if (exp_req.size() + exp_fill.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d outstanding, required 0", exp_req.size() + exp_fill.size()); end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_wrong_owner();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_miss_unit.md
CACHE_MISS_UNIT -- requirements
Module: cache_miss_unit

Interface
REQ-001 SHALL have parameter CACHE_ID, default 1: value driven and matched on rsp_cache_id (0 = I$, 1 = D$).
REQ-002 SHALL have parameter TIMEOUT, default 64: cycles allowed in a wait state before abort.
REQ-003 SHALL have port clock  in  1  single clock; all state on posedge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port miss_valid_i  in  1  refill request from cache, sampled only when miss_ready_o=1.
REQ-006 SHALL have port miss_addr_i  in  memory_request_t.addr width  line address to refill.
REQ-007 SHALL have port evict_valid_i  in  1  dirty victim accompanies the miss.
REQ-008 SHALL have port evict_addr_i  in  memory_request_t.addr width  victim line address.
REQ-009 SHALL have port evict_data_i  in  DCACHE_LINE_WIDTH  victim line data.
REQ-010 SHALL have port miss_ready_o  out  1  unit idle, new miss accepted.
REQ-011 SHALL have port req_valid_miss  out  1  one-cycle request pulse to memory arbiter.
REQ-012 SHALL have port req_info_miss  out  memory_request_t  addr/is_store/data of current request.
REQ-013 SHALL have port rsp_valid_miss  in  1  one-cycle response pulse from arbiter.
REQ-014 SHALL have port rsp_cache_id  in  1  response owner.
REQ-015 SHALL have port rsp_data_miss  in  DCACHE_LINE_WIDTH  response line data.
REQ-016 SHALL have port fill_valid_o  out  1  one-cycle refill pulse to cache.
REQ-017 SHALL have ports fill_addr_o (addr width) and fill_data_o (line width)  out  refill address/data, valid with fill_valid_o.
REQ-018 SHALL have port timeout_o  out  1  one-cycle abort pulse.

Function
REQ-019 FSM states SHALL be IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, REFILL.
REQ-020 IDLE: miss_ready_o=1; on miss_valid_i latch all inputs, go to WB_REQ if evict_valid_i else FILL_REQ; miss_valid_i outside IDLE SHALL be ignored.
REQ-021 WB_REQ: req_valid_miss=1 for exactly this cycle, req_info_miss={evict_addr, is_store=1, evict_data}; next WB_WAIT.
REQ-022 FILL_REQ: req_valid_miss=1 for exactly this cycle, req_info_miss={miss_addr, is_store=0, data='0}; next FILL_WAIT.
REQ-023 req_info_miss SHALL remain stable from the REQ cycle until the matching response.
REQ-024 A response matches only when rsp_valid_miss=1 and rsp_cache_id==CACHE_ID; non-matching or out-of-wait-state responses SHALL be ignored.
REQ-025 WB_WAIT + match: go to FILL_REQ (data ignored).
REQ-026 FILL_WAIT + match: register rsp_data_miss, go to REFILL.
REQ-027 REFILL: fill_valid_o=1 one cycle with latched addr/data; next IDLE.
REQ-028 Latency without writeback: miss accepted cycle N -> req pulse N+1 -> response cycle M -> fill_valid_o M+1 -> miss_ready_o M+2.
REQ-029 Watchdog SHALL clear on entering either WAIT state and increment each WAIT cycle; on reaching TIMEOUT-1 without match: timeout_o pulse, go IDLE, no fill.
REQ-030 Match and timeout in same cycle: match SHALL win, no timeout_o.
REQ-031 Counter width SHALL be $clog2(TIMEOUT) bits; no wrap occurs since it clears at abort.

Reset
REQ-032 On reset low, asynchronously: FSM=IDLE, miss_ready_o=1, req_valid_miss=0, req_info_miss='0, fill_valid_o=0, fill_addr_o='0, fill_data_o='0, timeout_o=0, watchdog=0.
REQ-033 Reset mid-operation SHALL discard the pending miss; a response arriving after reset release SHALL be ignored.

Structure
REQ-034 memory_request_t, line-width/address-width macros and the miss_state_t enum SHALL live in the shared soc package/header.
REQ-035 Watchdog SHALL be one sub-module, miss_watchdog (clear, enable, expire output, TIMEOUT parameter).

Verification
REQ-036 Clean miss: miss addr 'h40, no evict, response after 10 cycles -> one load req addr 'h40 is_store=0, fill_valid_o one cycle with data, ready 2 cycles after response.
REQ-037 Dirty miss: evict addr 'h10 data 'hAB.., miss 'h20 -> store req 'h10 first, load req 'h20 only after store response, then fill.
REQ-038 Wrong owner: CACHE_ID=1, inject rsp_cache_id=0 in FILL_WAIT -> no fill; later rsp_cache_id=1 -> fill.
REQ-039 Timeout: no response for 64 cycles -> timeout_o pulse, no fill_valid_o, miss_ready_o=1 next cycle; response on cycle 63 -> fill, no timeout.
REQ-040 Reset low in FILL_WAIT, then response after release -> all outputs at reset values, no fill_valid_o.
REQ-041 Back-to-back: miss_valid_i held high throughout -> second miss accepted exactly in first IDLE cycle after REFILL, no extra req pulses.
